mult_seq_gen: RTL and testbench

//  Parametrised sequential shift-add multiplier and successor to the combinational 32-bit unsigned multiplier.
//  - Retires one multiplier bit per cycle and returns a full 2*WIDTH product.
//  - Signed or unsigned operation is selected per transaction; optional early termination.
//  - Valid/ready handshakes on input and output; sits between operand sources and datapath consumers.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_sign_conv.sv | 14 +
 rtl/mult_seq_gen.sv | 131 +++++++++++++
 tb/tb_mult_seq_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and mode encodings for the sequential shift-add multiplier.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mult_sign_conv.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mult_sign_conv #(
  parameter int N = 32
) (
  input  logic [N-1:0] din,
  input  logic         neg,
  output logic [N-1:0] dout
);

  assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/mult_seq_gen.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, signed/unsigned per transaction.
// Latency: WIDTH cycles accept-to-OUT_VALID (EARLY_TERM=1: 1 + msb index of |B|, min 1).
// Backpressure: IN_READY only in IDLE; product held in DONE until OUT_READY.
module mult_seq_gen
  import mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SCLR,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 SIGNED,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   P
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  mult_state_t state, state_nxt;

  // mcand is kept pre-shifted so that in each CALC cycle it equals |A| << cnt
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    p_fin;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_shr;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             signed_mode;
  logic             neg_in;
  logic             accept;
  logic             last;

  assign signed_mode = (SIGNED == MODE_SIGNED);
  assign neg_in      = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
  assign accept      = IN_VALID && (state == IDLE);

  // |-2^(W-1)| wraps to 2^(W-1), which is correct when read as unsigned
  mult_sign_conv #(.N(WIDTH)) u_abs_a (
    .din  (A),
    .neg  (signed_mode & A[WIDTH-1]),
    .dout (a_abs)
  );

  mult_sign_conv #(.N(WIDTH)) u_abs_b (
    .din  (B),
    .neg  (signed_mode & B[WIDTH-1]),
    .dout (b_abs)
  );

  assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
  assign mplier_shr = mplier >> 1;
  assign last       = (cnt == CW'(WIDTH - 1)) || (EARLY_TERM && (mplier_shr == '0));

  // Sign is applied to the accumulator value of the final CALC cycle; -0 is 0
  mult_sign_conv #(.N(PW)) u_prod (
    .din  (acc_nxt),
    .neg  (neg),
    .dout (p_fin)
  );

  // State register; SCLR overrides everything
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     state <= IDLE;
    else if (SCLR)  state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift-add in CALC, register product on exit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      P      <= '0;
    end else if (SCLR) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      P      <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_abs};
      mplier <= b_abs;
      acc    <= '0;
      cnt    <= '0;
      neg    <= neg_in;
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier_shr;
      cnt    <= cnt + CW'(1);
      if (last) P <= p_fin;
    end
  end

endmodule

// File: tb/tb_mult_seq_gen.sv
// Self-checking bench: W=32 (no early termination) and W=8 (early termination) instances.
// Latency: measured per transaction from the accept edge.
// Backpressure: OUT_READY is held low for stretches to check the DONE hold behaviour.
module tb_mult_seq_gen;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=32, EARLY_TERM=0
  logic        sclr32 = 1'b0, iv32 = 1'b0, sg32 = 1'b0, or32 = 1'b0;
  logic        ir32, ov32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] p32;

  // W=8, EARLY_TERM=1
  logic        sclr8 = 1'b0, iv8 = 1'b0, sg8 = 1'b0, or8 = 1'b0;
  logic        ir8, ov8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  int n_total = 0;
  int n_pass  = 0;

  mult_seq_gen #(.WIDTH(32), .EARLY_TERM(1'b0)) dut32 (
    .CLK(clk), .RST_N(rst_n), .SCLR(sclr32), .IN_VALID(iv32), .IN_READY(ir32),
    .SIGNED(sg32), .A(a32), .B(b32), .OUT_VALID(ov32), .OUT_READY(or32), .P(p32)
  );

  mult_seq_gen #(.WIDTH(8), .EARLY_TERM(1'b1)) dut8 (
    .CLK(clk), .RST_N(rst_n), .SCLR(sclr8), .IN_VALID(iv8), .IN_READY(ir8),
    .SIGNED(sg8), .A(a8), .B(b8), .OUT_VALID(ov8), .OUT_READY(or8), .P(p8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic accept32(input logic s, input logic [31:0] a, input logic [31:0] b, input string nm);
    chk({nm, " in_ready"}, 64'(ir32), 64'd1);
    sg32 = s; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
  endtask

  task automatic wait32(input logic [63:0] ep, input int el, input string nm);
    int lat = 0;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(el));
    chk({nm, " p"}, p32, ep);
  endtask

  task automatic pop32();
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic txn32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ep, input int el, input string nm);
    accept32(s, a, b, nm);
    wait32(ep, el, nm);
    pop32();
  endtask

  task automatic txn8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] ep, input int el, input int hold, input string nm);
    int lat = 0;
    chk({nm, " in_ready"}, 64'(ir8), 64'd1);
    sg8 = s; a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    while (!ov8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(el));
    chk({nm, " p"}, 64'(p8), 64'(ep));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) chk({nm, " held"}, {47'd0, ov8, p8}, {47'd0, 1'b1, ep});
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  vec_t v32 [10];
  vec_t v8  [7];

  initial begin
    logic [63:0] ea, eb, ep;
    logic [15:0] ea8, eb8, ep8;
    logic [7:0]  ra8, rb8, babs;
    logic [31:0] ra, rb;
    logic        rs;
    int          el, hold;
    logic        seen;

    v32[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 32};
    v32[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF, 32};
    v32[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 32};
    v32[3] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 32};
    v32[4] = '{1'b0, 32'h00000000, 32'h12345678, 64'h00000000_00000000, 32};
    v32[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000, 32};
    v32[6] = '{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000, 32};
    v32[7] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2, 32};
    v32[8] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000, 32};
    v32[9] = '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 32};

    v8[0] = '{1'b0, 32'h07, 32'h03, 64'h0015, 2};
    v8[1] = '{1'b0, 32'h07, 32'h00, 64'h0000, 1};
    v8[2] = '{1'b1, 32'h80, 32'h80, 64'h4000, 8};
    v8[3] = '{1'b1, 32'hFD, 32'h05, 64'hFFF1, 3};
    v8[4] = '{1'b1, 32'h05, 32'hFD, 64'hFFF1, 2};
    v8[5] = '{1'b0, 32'hFF, 32'hFF, 64'hFE01, 8};
    v8[6] = '{1'b0, 32'hFF, 32'h01, 64'h00FF, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset32", {60'd0, ir32, ov32, 2'b00} | {p32 != 64'd0, 63'd0}, {60'd0, 1'b1, 1'b0, 2'b00});
    chk("reset8",  {46'd0, ir8, ov8, p8}, {46'd0, 1'b1, 1'b0, 16'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      txn32(v32[i].sgn, v32[i].a, v32[i].b, v32[i].p, v32[i].lat, $sformatf("v32[%0d]", i));

    for (int i = 0; i < 7; i++)
      txn8(v8[i].sgn, v8[i].a[7:0], v8[i].b[7:0], v8[i].p[15:0], v8[i].lat, 0,
           $sformatf("v8[%0d]", i));

    // Backpressure: product held, operands offered during DONE are not taken
    accept32(1'b0, 32'd3, 32'd4, "bp first");
    wait32(64'd12, 32, "bp first");
    sg32 = 1'b0; a32 = 32'd5; b32 = 32'd6; iv32 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d", c), {p32[61:0], ov32, ir32}, {62'd12, 1'b1, 1'b0});
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    chk("bp released", {p32[61:0], ov32, ir32}, {62'd12, 1'b0, 1'b1});
    @(posedge clk); #1;
    iv32 = 1'b0;
    wait32(64'd30, 32, "bp second");
    pop32();

    // Asynchronous reset in the middle of CALC
    accept32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "arst");
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst outputs", {p32[61:0], ov32, ir32}, {62'd0, 1'b0, 1'b1});
    chk("arst p_hi", {62'd0, p32[63:62]}, 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn32(1'b0, 32'h00010001, 32'h00010001, 64'h00000001_00020001, 32, "after arst");

    // Synchronous clear in the middle of CALC
    accept32(1'b0, 32'hFFFFFFFF, 32'h00000002, "sclr");
    repeat (9) @(posedge clk);
    #1;
    chk("sclr before edge", p32, 64'h00000001_00020001);
    sclr32 = 1'b1;
    @(posedge clk); #1;
    sclr32 = 1'b0;
    chk("sclr outputs", {p32[61:0], ov32, ir32}, {62'd0, 1'b0, 1'b1});
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) seen = 1'b1;
    end
    chk("sclr discarded", 64'(seen), 64'd0);
    txn32(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFD, 64'd9, 32, "after sclr");

    // Random W=32, no early termination
    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      ea = rs ? {{32{ra[31]}}, ra} : {32'd0, ra};
      eb = rs ? {{32{rb[31]}}, rb} : {32'd0, rb};
      ep = ea * eb;
      accept32(rs, ra, rb, $sformatf("r32[%0d]", i));
      wait32(ep, 32, $sformatf("r32[%0d]", i));
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      if (hold > 0) chk($sformatf("r32[%0d] held", i), {p32[62:0], ov32}, {ep[62:0], 1'b1});
      pop32();
    end

    // Random W=8, early termination
    for (int i = 0; i < 1500; i++) begin
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      rb8 = rb8 >> $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) rb8 = ~rb8;
      rs = 1'($urandom_range(0, 1));
      ea8 = rs ? {{8{ra8[7]}}, ra8} : {8'd0, ra8};
      eb8 = rs ? {{8{rb8[7]}}, rb8} : {8'd0, rb8};
      ep8 = ea8 * eb8;
      babs = (rs && rb8[7]) ? (~rb8 + 8'd1) : rb8;
      el = 1;
      for (int k = 0; k < 8; k++)
        if (babs[k]) el = k + 1;
      txn8(rs, ra8, rb8, ep8, el, $urandom_range(0, 2), $sformatf("r8[%0d]", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
